// File: rtl/axis_ask_tx_arbiter.sv
// rtl/axis_ask_tx_arbiter.sv - round-robin stream arbiter sharing one ASK/UART TX wrapper
// Grant ends on tlast or after MAX_BURST accepted beats; one IDLE bubble between grants.
module axis_ask_tx_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]   s_tdata,
  input  logic [NUM_PORTS-1:0]              s_tvalid,
  input  logic [NUM_PORTS-1:0]              s_tlast,
  output logic [NUM_PORTS-1:0]              s_tready,
  output logic [DATA_WIDTH-1:0]             m_tdata,
  output logic                              m_tvalid,
  output logic                              m_tlast,
  input  logic                              m_tready,
  output logic [$clog2(NUM_PORTS)-1:0]      grant_id,
  output logic                              grant_active
);

  localparam int IDX_W = $clog2(NUM_PORTS);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state;
  logic [IDX_W-1:0] gnt;
  logic [IDX_W-1:0] rr_ptr;
  logic [CNT_W-1:0] beat_cnt;
  logic [CNT_W-1:0] beat_next;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W:0]   cand;
  logic             accept;

  // Walk offsets from farthest to nearest so the port closest to rr_ptr wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      cand = {1'b0, rr_ptr} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NUM_PORTS)) begin
        cand = cand - (IDX_W+1)'(NUM_PORTS);
      end
      if (s_tvalid[cand[IDX_W-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // Datapath depends only on registered grant state, never on m_tready for m_tvalid.
  always_comb begin
    m_tdata  = '0;
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    s_tready = '0;
    if (state == GRANT) begin
      m_tdata       = s_tdata[int'(gnt)*DATA_WIDTH +: DATA_WIDTH];
      m_tvalid      = s_tvalid[gnt];
      m_tlast       = s_tlast[gnt];
      s_tready[gnt] = m_tready;
    end
  end

  assign accept       = m_tvalid & m_tready;
  assign beat_next    = beat_cnt + CNT_W'(1);
  assign grant_id     = gnt;
  assign grant_active = (state == GRANT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            gnt      <= pick_idx;
            beat_cnt <= '0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (accept) begin
            beat_cnt <= beat_next;
            if (m_tlast || (beat_next == CNT_W'(MAX_BURST))) begin
              state  <= IDLE;
              rr_ptr <= (gnt == IDX_W'(NUM_PORTS - 1)) ? '0 : gnt + IDX_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
